jlsemi_util_clkmux_seq_ctrl: RTL and testbench
==============================================

Name: jlsemi_util_clkmux_seq_ctrl

Overview:
Parametrised N-way clock-switch sequencer. It runs on one always-on control clock and drives the binary select of an N-input clock mux cell plus one clock-gate enable per source. It replaces a bare select with a glitch-safe sequence: gate off, switch the mux, settle, gate on. A DFT override forces the last source with all gates open.

Parameters:
NUM_CLK, 4, number of selectable clock sources (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CLK
GATE_OFF_CYC, 4, control-clock cycles all gates stay closed before the mux select changes (>=1)
SETTLE_CYC, 4, control-clock cycles after the mux select changes before the new gate opens (>=1)
RST_SEL, 0, source selected and gated-on out of reset (< NUM_CLK)

Ports:
clk_i  input  1  always-on control clock
rst_n_i  input  1  asynchronous active-low reset
sel_req_i  input  SEL_W  requested source index
sel_req_vld_i  input  1  request strobe, sampled only when busy_o=0
dft_test_clk_en  input  1  DFT override: force source NUM_CLK-1, all gates open
mux_sel_o  output  SEL_W  select to the clock mux cell
clk_gate_en_o  output  NUM_CLK  per-source clock-gate enable, one-hot or zero in functional mode
cur_sel_o  output  SEL_W  source currently committed and gated on
busy_o  output  1  sequence in progress
sel_ack_o  output  1  one-cycle pulse: request completed
sel_err_o  output  1  one-cycle pulse: request rejected (index >= NUM_CLK)

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is asynchronous, active-low.
- Reset values: state=IDLE, mux_sel_o=RST_SEL, clk_gate_en_o=onehot(RST_SEL), cur_sel_o=RST_SEL, busy_o=0, sel_ack_o=0, sel_err_o=0, counter=0.
- Registered outputs. The DFT override is the only combinational path.
- FSM states are IDLE, GATE_OFF, SWITCH and SETTLE. busy_o=1 in every state except IDLE.
- IDLE, request sampled in cycle T:
  - sel_req_i >= NUM_CLK: sel_err_o=1 in cycle T+1; no other change.
  - sel_req_i == cur_sel_o: sel_ack_o=1 in cycle T+1; gates and select unchanged.
  - Otherwise: latch target; at the edge ending T, go to GATE_OFF, set clk_gate_en_o=0 and load the counter.
- GATE_OFF: holds for exactly GATE_OFF_CYC cycles (T+1..T+G). It then goes to SWITCH, with mux_sel_o<=target at that edge.
- SWITCH: 1 cycle. It then goes to SETTLE and loads the counter.
- SETTLE: holds for exactly SETTLE_CYC cycles. At the exit edge:
  - clk_gate_en_o<=onehot(target), cur_sel_o<=target, sel_ack_o<=1 for one cycle;
  - state goes to IDLE.
- Timing totals:
  - sel_ack_o is high in cycle T+G+S+2.
  - All gates are closed for G+S+1 cycles.
  - mux_sel_o changes only while all gates are closed.
- While busy_o=1, sel_req_vld_i is ignored: no queue, no ack, no err. The requester must wait for busy_o=0.
- sel_ack_o and sel_err_o are never high together. Each is high for exactly one cycle.
- DFT override, dft_test_clk_en=1:
  - mux_sel_o=NUM_CLK-1 and clk_gate_en_o=all ones, combinationally.
  - FSM state, counter and registered outputs freeze.
  - Requests are ignored. Pending ack/err pulses are suppressed at the outputs; the registered pulses still clear after one cycle.
  - On deassert, outputs return to the registered values and a frozen sequence resumes from where it stopped.
- Reset asserted mid-sequence: all outputs return asynchronously to reset values and the latched target is discarded.
- Counter width is clog2(max(GATE_OFF_CYC,SETTLE_CYC)+1). It counts down and exits at 1, so there is no wrap.

Test Plan:
- Reset with RST_SEL=0, NUM_CLK=4 -> mux_sel_o=0, clk_gate_en_o=4'b0001, cur_sel_o=0, busy_o=0.
- Request sel=2 at cycle T (G=4,S=4):
  - gate_en=0 from T+1; mux_sel_o=2 from T+5;
  - gate_en=4'b0100, cur_sel_o=2 and sel_ack_o=1 at T+10; busy_o low at T+10.
- Request sel equal to cur_sel_o -> sel_ack_o pulse at T+1, busy_o stays 0, gates unchanged. Request sel=5 with SEL_W=3, NUM_CLK=4 -> sel_err_o pulse at T+1, no state change.
- Second request during GATE_OFF -> ignored; only the first target is applied; exactly one ack.
- dft_test_clk_en=1 mid-SETTLE for 7 cycles:
  - during override: mux_sel_o=3, clk_gate_en_o=4'b1111;
  - after deassert: sequence completes with ack delayed by exactly 7 cycles.
- rst_n_i pulsed low during SWITCH -> immediate return to the reset values above; a subsequent request completes normally.

Source files
------------

// File: rtl/jlsemi_util_clkmux_seq_ctrl.sv
// Glitch-safe N-way clock-switch sequencer: gate off, switch mux, settle, gate on.
// All outputs registered except the DFT override path, which forces last source with all gates open.
module jlsemi_util_clkmux_seq_ctrl #(
  parameter int NUM_CLK      = 4,
  parameter int SEL_W        = 2,
  parameter int GATE_OFF_CYC = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int RST_SEL      = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [SEL_W-1:0]   sel_req_i,
  input  logic               sel_req_vld_i,
  input  logic               dft_test_clk_en,
  output logic [SEL_W-1:0]   mux_sel_o,
  output logic [NUM_CLK-1:0] clk_gate_en_o,
  output logic [SEL_W-1:0]   cur_sel_o,
  output logic               busy_o,
  output logic               sel_ack_o,
  output logic               sel_err_o
);

  localparam int                 MAX_CYC   = (GATE_OFF_CYC > SETTLE_CYC) ? GATE_OFF_CYC : SETTLE_CYC;
  localparam int                 CNT_W     = $clog2(MAX_CYC + 1);
  localparam logic [SEL_W-1:0]   RST_SEL_V = SEL_W'(RST_SEL);
  localparam logic [SEL_W-1:0]   DFT_SEL_V = SEL_W'(NUM_CLK - 1);
  localparam logic [SEL_W:0]     SEL_LIMIT = (SEL_W + 1)'(NUM_CLK);
  localparam logic [NUM_CLK-1:0] RST_GATE  = NUM_CLK'(1) << RST_SEL;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_GOFF  = CNT_W'(GATE_OFF_CYC);
  localparam logic [CNT_W-1:0]   CNT_SETL  = CNT_W'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [SEL_W-1:0]     target;
  logic [SEL_W-1:0]     mux_q;
  logic [NUM_CLK-1:0]   gate_q;
  logic [SEL_W-1:0]     cur_q;
  logic                 busy_q;
  logic                 ack_q;
  logic                 err_q;

  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = NUM_CLK'(1) << s;
  endfunction

  // Override freezes the sequence in place; only the ack/err pulses keep self-clearing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= RST_SEL_V;
      mux_q  <= RST_SEL_V;
      gate_q <= RST_GATE;
      cur_q  <= RST_SEL_V;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (!dft_test_clk_en) begin
        case (state)
          IDLE: begin
            if (sel_req_vld_i) begin
              if ({1'b0, sel_req_i} >= SEL_LIMIT) begin
                err_q <= 1'b1;
              end else if (sel_req_i == cur_q) begin
                ack_q <= 1'b1;
              end else begin
                target <= sel_req_i;
                gate_q <= '0;
                cnt    <= CNT_GOFF;
                busy_q <= 1'b1;
                state  <= GATE_OFF;
              end
            end
          end
          GATE_OFF: begin
            if (cnt == CNT_ONE) begin
              mux_q <= target;
              state <= SWITCH;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          SWITCH: begin
            cnt   <= CNT_SETL;
            state <= SETTLE;
          end
          SETTLE: begin
            if (cnt == CNT_ONE) begin
              gate_q <= onehot(target);
              cur_q  <= target;
              ack_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mux_sel_o     = dft_test_clk_en ? DFT_SEL_V : mux_q;
  assign clk_gate_en_o = dft_test_clk_en ? '1 : gate_q;
  assign cur_sel_o     = cur_q;
  assign busy_o        = busy_q;
  assign sel_ack_o     = ack_q & ~dft_test_clk_en;
  assign sel_err_o     = err_q & ~dft_test_clk_en;

  ack_err_excl: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(ack_q && err_q));

endmodule

// File: tb/tb_jlsemi_util_clkmux_seq_ctrl.sv
// Directed bench for the clock-switch sequencer: vector table plus DFT and reset corner sequences.
module tb_jlsemi_util_clkmux_seq_ctrl;
  localparam int NUM_CLK = 4;
  localparam int SEL_W   = 3;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b1;
  logic [SEL_W-1:0]   sel_req_i = '0;
  logic               sel_req_vld_i = 1'b0;
  logic               dft_test_clk_en = 1'b0;
  logic [SEL_W-1:0]   mux_sel_o;
  logic [NUM_CLK-1:0] clk_gate_en_o;
  logic [SEL_W-1:0]   cur_sel_o;
  logic               busy_o;
  logic               sel_ack_o;
  logic               sel_err_o;

  int checks = 0;
  int errors = 0;

  jlsemi_util_clkmux_seq_ctrl #(
    .NUM_CLK(NUM_CLK), .SEL_W(SEL_W), .GATE_OFF_CYC(4), .SETTLE_CYC(4), .RST_SEL(0)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sel_req_i(sel_req_i), .sel_req_vld_i(sel_req_vld_i),
    .dft_test_clk_en(dft_test_clk_en), .mux_sel_o(mux_sel_o), .clk_gate_en_o(clk_gate_en_o),
    .cur_sel_o(cur_sel_o), .busy_o(busy_o), .sel_ack_o(sel_ack_o), .sel_err_o(sel_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       vld;
    logic [2:0] sel;
    logic [2:0] mux;
    logic [3:0] gate;
    logic [2:0] cur;
    logic       busy;
    logic       ack;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [2:0] mux, input logic [3:0] gate,
                         input logic [2:0] cur, input logic busy, input logic ack, input logic err);
    chk("mux_sel", idx, 32'(mux_sel_o), 32'(mux));
    chk("gate_en", idx, 32'(clk_gate_en_o), 32'(gate));
    chk("cur_sel", idx, 32'(cur_sel_o), 32'(cur));
    chk("busy", idx, 32'(busy_o), 32'(busy));
    chk("ack", idx, 32'(sel_ack_o), 32'(ack));
    chk("err", idx, 32'(sel_err_o), 32'(err));
  endtask

  // Drive one cycle's inputs just after the edge, then let outputs settle before checking.
  task automatic cyc(input logic vld, input logic [SEL_W-1:0] sel, input logic dft);
    @(posedge clk_i);
    #1;
    sel_req_vld_i   = vld;
    sel_req_i       = sel;
    dft_test_clk_en = dft;
    #1;
  endtask

  task automatic add(input logic vld, input logic [2:0] sel, input logic [2:0] mux, input logic [3:0] gate,
                     input logic [2:0] cur, input logic busy, input logic ack, input logic err);
    vec_t v;
    v.vld = vld; v.sel = sel; v.mux = mux; v.gate = gate;
    v.cur = cur; v.busy = busy; v.ack = ack; v.err = err;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // idle, same-select ack, out-of-range errors, then a full 0 -> 2 switch (T = row 7)
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0);
    add(1, 0, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 0, 1, 0);
    add(1, 5, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 1);
    add(1, 4, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 1);
    add(1, 2, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
    add(1, 1, 0, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 2, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 2, 4'b0000, 0, 1, 0, 0);
    add(1, 7, 2, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 2, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 2, 4'b0000, 0, 1, 0, 0);
    add(0, 0, 2, 4'b0100, 2, 0, 1, 0);
    add(0, 0, 2, 4'b0100, 2, 0, 0, 0);
    add(1, 2, 2, 4'b0100, 2, 0, 0, 0);
    add(0, 0, 2, 4'b0100, 2, 0, 1, 0);
    add(0, 0, 2, 4'b0100, 2, 0, 0, 0);

    #1 rst_n_i = 1'b0;
    #2 chk_all(900, 0, 4'b0001, 0, 0, 0, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].vld, tbl[i].sel, 1'b0);
      chk_all(i, tbl[i].mux, tbl[i].gate, tbl[i].cur, tbl[i].busy, tbl[i].ack, tbl[i].err);
    end

    // pending ack suppressed by override and not re-emitted afterwards
    cyc(1, 2, 0);
    cyc(0, 0, 1);
    chk_all(100, 3, 4'b1111, 2, 0, 0, 0);
    cyc(0, 0, 0);
    chk_all(101, 2, 4'b0100, 2, 0, 0, 0);

    // 2 -> 1 switch with override held for T+7..T+13 (mid-SETTLE); ack moves from T+10 to T+17
    cyc(1, 1, 0);
    for (int k = 1; k <= 18; k++) begin
      if (k >= 7 && k <= 13) begin
        cyc((k == 9), 3'd0, 1'b1);
        chk_all(200 + k, 3, 4'b1111, 2, 1, 0, 0);
      end else begin
        cyc(0, 0, 0);
        if (k <= 4)       chk_all(200 + k, 2, 4'b0000, 2, 1, 0, 0);
        else if (k <= 16) chk_all(200 + k, 1, 4'b0000, 2, 1, 0, 0);
        else if (k == 17) chk_all(200 + k, 1, 4'b0010, 1, 0, 1, 0);
        else              chk_all(200 + k, 1, 4'b0010, 1, 0, 0, 0);
      end
    end

    // reset pulsed during SWITCH (T+5) of a 1 -> 3 switch
    cyc(1, 3, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 0, 0);
    chk_all(300, 3, 4'b0000, 1, 1, 0, 0);
    #1 rst_n_i = 1'b0;
    #1 chk_all(301, 0, 4'b0001, 0, 0, 0, 0);
    cyc(0, 0, 0);
    #1 rst_n_i = 1'b1;
    chk_all(302, 0, 4'b0001, 0, 0, 0, 0);

    // subsequent 0 -> 2 request completes with nominal timing
    cyc(1, 2, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 0, 0);
    chk_all(400, 2, 4'b0000, 0, 1, 0, 0);
    cyc(0, 0, 0);
    chk_all(401, 2, 4'b0100, 2, 0, 1, 0);
    cyc(0, 0, 0);
    chk_all(402, 2, 4'b0100, 2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
